// File: rtl/fitness_pkg.sv
// Shared types for the mux fitness evaluator: FSM state enum
// and the 2^N vector-count helper.
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } fit_state_t;

  function automatic int pow2(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/vector_sweeper.sv
// Vector counter plus settle counter for the fitness sweep.
// Ports: clk, rst, clear/advance/settling controls; vec,
// sample_now (settle time elapsed), last_vec (vec is all ones).
module vector_sweeper
  import fitness_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  input  logic            settling,
  output logic [N_IN-1:0] vec,
  output logic            sample_now,
  output logic            last_vec
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Counter runs RELOAD..0, giving SETTLE_CYCLES cycles in SETTLE.
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (clear) begin
      vec_d = '0;
      cnt_d = RELOAD;
    end else if (advance) begin
      vec_d = vec_q + N_IN'(1);
      cnt_d = RELOAD;
    end else if (settling && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= RELOAD;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec        = vec_q;
  assign sample_now = settling && (cnt_q == '0);
  assign last_vec   = &vec_q;

endmodule

// File: rtl/mux_fitness_evaluator.sv
// Exhaustive equivalence sweep of a candidate vs golden circuit.
// Ports: clk, rst (sync, active-high), start, stim_out, golden_in,
// cand_in -> busy, done, results_valid, mismatch_count, fail_map,
// pass. Macro FITNESS_EARLY_ABORT_EN stops at the first mismatch.
module mux_fitness_evaluator
  import fitness_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       stim_out,
  input  logic                  golden_in,
  input  logic                  cand_in,
  output logic                  busy,
  output logic                  done,
  output logic                  results_valid,
  output logic [N_IN:0]         mismatch_count,
  output logic [pow2(N_IN)-1:0] fail_map,
  output logic                  pass
);

  localparam int NV = pow2(N_IN);

  fit_state_t state_q, state_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rv_q, rv_d;
  logic [N_IN:0] cnt_q, cnt_d;
  logic [NV-1:0] map_q, map_d;

  logic            sw_clear;
  logic            sw_adv;
  logic            settling;
  logic [N_IN-1:0] vec;
  logic            sample_now;
  logic            last_vec;
  logic            mis;

  assign settling = (state_q == SETTLE);
  assign mis      = golden_in ^ cand_in;

  vector_sweeper #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_sweeper (
    .clk        (clk),
    .rst        (rst),
    .clear      (sw_clear),
    .advance    (sw_adv),
    .settling   (settling),
    .vec        (vec),
    .sample_now (sample_now),
    .last_vec   (last_vec)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rv_d     = rv_q;
    cnt_d    = cnt_q;
    map_d    = map_q;
    sw_clear = 1'b0;
    sw_adv   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = '0;
          map_d    = '0;
          rv_d     = 1'b0;
          busy_d   = 1'b1;
          sw_clear = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (sample_now) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mis) begin
          map_d[vec] = 1'b1;
          cnt_d      = cnt_q + (N_IN+1)'(1);
        end
`ifdef FITNESS_EARLY_ABORT_EN
        if (mis || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_d = DONE;
        end else begin
          sw_adv  = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      cnt_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
    end
  end

  assign stim_out       = vec;
  assign busy           = busy_q;
  assign done           = done_q;
  assign results_valid  = rv_q;
  assign mismatch_count = cnt_q;
  assign fail_map       = map_q;
  assign pass           = rv_q && (cnt_q == '0);

endmodule
